// File: rtl/serial_pattern_gen.sv
// Serial pattern transmitter: shifts a loaded word out MSB-first with start/busy/done
// handshake and keeps a golden count of overlapping "00" pairs on the serial line.
module serial_pattern_gen #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned LEN_W = 7,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             stop,
    input  logic             rpt,
    input  logic [WIDTH-1:0] data,
    input  logic [LEN_W-1:0] len,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] exp_cnt
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    localparam logic [LEN_W-1:0] WidthL = LEN_W'(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   copy_q, copy_d;
    logic [LEN_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               rpt_q, rpt_d;
    logic               out_q, out_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   exp_cnt_q, exp_cnt_d;

    logic               drive_bit;
    logic               new_bit;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        copy_d    = copy_q;
        bit_cnt_d = bit_cnt_q;
        len_d     = len_q;
        rpt_d     = rpt_q;
        out_d     = out_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        exp_cnt_d = exp_cnt_q;
        drive_bit = 1'b0;
        new_bit   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    shift_d   = data << 1;
                    copy_d    = data;
                    len_d     = (len == '0 || len > WidthL) ? WidthL : len;
                    rpt_d     = rpt;
                    out_d     = data[WIDTH-1];
                    valid_d   = 1'b1;
                    bit_cnt_d = LEN_W'(1);
                    exp_cnt_d = '0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                if (stop) begin
                    state_d = StIdle;
                    out_d   = 1'b0;
                    valid_d = 1'b0;
                end else if (bit_cnt_q == len_q) begin
                    if (rpt_q) begin
                        // Reload on the same edge so the repeated stream has no gap.
                        drive_bit = 1'b1;
                        new_bit   = copy_q[WIDTH-1];
                        shift_d   = copy_q << 1;
                        bit_cnt_d = LEN_W'(1);
                    end else begin
                        state_d = StDone;
                        out_d   = 1'b0;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    drive_bit = 1'b1;
                    new_bit   = shift_q[WIDTH-1];
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q + LEN_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (drive_bit) begin
            out_d = new_bit;
            if (!out_q && valid_q && !new_bit && exp_cnt_q != '1) begin
                exp_cnt_d = exp_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            copy_q    <= '0;
            bit_cnt_q <= '0;
            len_q     <= '0;
            rpt_q     <= 1'b0;
            out_q     <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            exp_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            copy_q    <= copy_d;
            bit_cnt_q <= bit_cnt_d;
            len_q     <= len_d;
            rpt_q     <= rpt_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            exp_cnt_q <= exp_cnt_d;
        end
    end

    assign out     = out_q;
    assign valid   = valid_q;
    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign exp_cnt = exp_cnt_q;

endmodule
